// File: rtl/axi4_lite_ram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi4_lite_ram_arbiter : two-master round-robin AXI4-Lite arbiter, one RAM slave
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module axi4_lite_ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_aw_valid,
    input  logic [ADDR_WIDTH-1:0] m0_aw_addr,
    output logic                  m0_aw_ready,
    input  logic                  m0_w_valid,
    input  logic [DATA_WIDTH-1:0] m0_w_data,
    output logic                  m0_w_ready,
    output logic                  m0_b_valid,
    output logic [1:0]            m0_b_resp,
    input  logic                  m0_b_ready,
    input  logic                  m0_ar_valid,
    input  logic [ADDR_WIDTH-1:0] m0_ar_addr,
    output logic                  m0_ar_ready,
    output logic                  m0_r_valid,
    output logic [DATA_WIDTH-1:0] m0_r_data,
    output logic [1:0]            m0_r_resp,
    input  logic                  m0_r_ready,
    input  logic                  m1_aw_valid,
    input  logic [ADDR_WIDTH-1:0] m1_aw_addr,
    output logic                  m1_aw_ready,
    input  logic                  m1_w_valid,
    input  logic [DATA_WIDTH-1:0] m1_w_data,
    output logic                  m1_w_ready,
    output logic                  m1_b_valid,
    output logic [1:0]            m1_b_resp,
    input  logic                  m1_b_ready,
    input  logic                  m1_ar_valid,
    input  logic [ADDR_WIDTH-1:0] m1_ar_addr,
    output logic                  m1_ar_ready,
    output logic                  m1_r_valid,
    output logic [DATA_WIDTH-1:0] m1_r_data,
    output logic [1:0]            m1_r_resp,
    input  logic                  m1_r_ready,
    output logic                  ram_aw_valid,
    output logic [ADDR_WIDTH-1:0] ram_aw_addr,
    input  logic                  ram_aw_ready,
    output logic                  ram_w_valid,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    input  logic                  ram_w_ready,
    input  logic                  ram_b_valid,
    input  logic [1:0]            ram_b_resp,
    output logic                  ram_b_ready,
    output logic                  ram_ar_valid,
    output logic [ADDR_WIDTH-1:0] ram_ar_addr,
    input  logic                  ram_ar_ready,
    input  logic                  ram_r_valid,
    input  logic [DATA_WIDTH-1:0] ram_r_data,
    input  logic [1:0]            ram_r_resp,
    output logic                  ram_r_ready,
    output logic [1:0]            grant,
    output logic                  busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [1:0] grant_q, grant_d;

    logic req0, req1, pick, pick_aw;
    assign req0    = m0_aw_valid | m0_ar_valid;
    assign req1    = m1_aw_valid | m1_ar_valid;
    // On a tie the master that did not own the bus last time wins.
    assign pick    = (req0 & req1) ? ~last_q : req1;
    assign pick_aw = pick ? m1_aw_valid : m0_aw_valid;

    logic                  sel_aw_valid, sel_w_valid, sel_b_ready;
    logic                  sel_ar_valid, sel_r_ready;
    logic [ADDR_WIDTH-1:0] sel_aw_addr, sel_ar_addr;
    logic [DATA_WIDTH-1:0] sel_w_data;
    assign sel_aw_valid = owner_q ? m1_aw_valid : m0_aw_valid;
    assign sel_aw_addr  = owner_q ? m1_aw_addr  : m0_aw_addr;
    assign sel_w_valid  = owner_q ? m1_w_valid  : m0_w_valid;
    assign sel_w_data   = owner_q ? m1_w_data   : m0_w_data;
    assign sel_b_ready  = owner_q ? m1_b_ready  : m0_b_ready;
    assign sel_ar_valid = owner_q ? m1_ar_valid : m0_ar_valid;
    assign sel_ar_addr  = owner_q ? m1_ar_addr  : m0_ar_addr;
    assign sel_r_ready  = owner_q ? m1_r_ready  : m0_r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    state_d = pick_aw ? S_WRITE : S_READ;
                    owner_d = pick;
                    last_d  = pick;
                    grant_d = pick ? 2'b10 : 2'b01;
                end
            end
            S_WRITE: begin
                if (ram_b_valid && ram_b_ready) begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                end
            end
            S_READ: begin
                if (ram_r_valid && ram_r_ready) begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    assign grant = grant_q;

    always_comb begin
        busy         = 1'b0;
        ram_aw_valid = 1'b0;
        ram_aw_addr  = '0;
        ram_w_valid  = 1'b0;
        ram_w_data   = '0;
        ram_b_ready  = 1'b0;
        ram_ar_valid = 1'b0;
        ram_ar_addr  = '0;
        ram_r_ready  = 1'b0;
        m0_aw_ready = 1'b0; m0_w_ready = 1'b0; m0_b_valid = 1'b0; m0_b_resp = '0;
        m0_ar_ready = 1'b0; m0_r_valid = 1'b0; m0_r_data  = '0;   m0_r_resp = '0;
        m1_aw_ready = 1'b0; m1_w_ready = 1'b0; m1_b_valid = 1'b0; m1_b_resp = '0;
        m1_ar_ready = 1'b0; m1_r_valid = 1'b0; m1_r_data  = '0;   m1_r_resp = '0;
        case (state_q)
            S_IDLE: begin
            end
            S_WRITE: begin
                busy         = 1'b1;
                ram_aw_valid = sel_aw_valid;
                ram_aw_addr  = sel_aw_addr;
                ram_w_valid  = sel_w_valid;
                ram_w_data   = sel_w_data;
                ram_b_ready  = sel_b_ready;
                if (owner_q) begin
                    m1_aw_ready = ram_aw_ready; m1_w_ready = ram_w_ready;
                    m1_b_valid  = ram_b_valid;  m1_b_resp  = ram_b_resp;
                end else begin
                    m0_aw_ready = ram_aw_ready; m0_w_ready = ram_w_ready;
                    m0_b_valid  = ram_b_valid;  m0_b_resp  = ram_b_resp;
                end
            end
            S_READ: begin
                busy         = 1'b1;
                ram_ar_valid = sel_ar_valid;
                ram_ar_addr  = sel_ar_addr;
                ram_r_ready  = sel_r_ready;
                if (owner_q) begin
                    m1_ar_ready = ram_ar_ready; m1_r_valid = ram_r_valid;
                    m1_r_data   = ram_r_data;   m1_r_resp  = ram_r_resp;
                end else begin
                    m0_ar_ready = ram_ar_ready; m0_r_valid = ram_r_valid;
                    m0_r_data   = ram_r_data;   m0_r_resp  = ram_r_resp;
                end
            end
            default: begin
                busy         = 1'bx;
                ram_aw_valid = 1'bx; ram_aw_addr = 'x; ram_w_valid = 1'bx; ram_w_data = 'x;
                ram_b_ready  = 1'bx; ram_ar_valid = 1'bx; ram_ar_addr = 'x; ram_r_ready = 1'bx;
                m0_aw_ready = 1'bx; m0_w_ready = 1'bx; m0_b_valid = 1'bx; m0_b_resp = 'x;
                m0_ar_ready = 1'bx; m0_r_valid = 1'bx; m0_r_data  = 'x;   m0_r_resp = 'x;
                m1_aw_ready = 1'bx; m1_w_ready = 1'bx; m1_b_valid = 1'bx; m1_b_resp = 'x;
                m1_ar_ready = 1'bx; m1_r_valid = 1'bx; m1_r_data  = 'x;   m1_r_resp = 'x;
            end
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_ram_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi4_lite_ram_arbiter : self-checking bench with a behavioural RAM slave
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_axi4_lite_ram_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          m_aw_valid[2], m_w_valid[2], m_b_ready[2], m_ar_valid[2], m_r_ready[2];
    logic [AW-1:0] m_aw_addr[2], m_ar_addr[2];
    logic [DW-1:0] m_w_data[2];
    logic          m_aw_ready[2], m_w_ready[2], m_b_valid[2], m_ar_ready[2], m_r_valid[2];
    logic [1:0]    m_b_resp[2], m_r_resp[2];
    logic [DW-1:0] m_r_data[2];

    logic          ram_aw_valid, ram_aw_ready, ram_w_valid, ram_w_ready, ram_b_valid, ram_b_ready;
    logic          ram_ar_valid, ram_ar_ready, ram_r_valid, ram_r_ready;
    logic [AW-1:0] ram_aw_addr, ram_ar_addr;
    logic [DW-1:0] ram_w_data, ram_r_data;
    logic [1:0]    ram_b_resp, ram_r_resp;
    logic [1:0]    grant;
    logic          busy;

    axi4_lite_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_aw_valid(m_aw_valid[0]), .m0_aw_addr(m_aw_addr[0]), .m0_aw_ready(m_aw_ready[0]),
        .m0_w_valid(m_w_valid[0]), .m0_w_data(m_w_data[0]), .m0_w_ready(m_w_ready[0]),
        .m0_b_valid(m_b_valid[0]), .m0_b_resp(m_b_resp[0]), .m0_b_ready(m_b_ready[0]),
        .m0_ar_valid(m_ar_valid[0]), .m0_ar_addr(m_ar_addr[0]), .m0_ar_ready(m_ar_ready[0]),
        .m0_r_valid(m_r_valid[0]), .m0_r_data(m_r_data[0]), .m0_r_resp(m_r_resp[0]), .m0_r_ready(m_r_ready[0]),
        .m1_aw_valid(m_aw_valid[1]), .m1_aw_addr(m_aw_addr[1]), .m1_aw_ready(m_aw_ready[1]),
        .m1_w_valid(m_w_valid[1]), .m1_w_data(m_w_data[1]), .m1_w_ready(m_w_ready[1]),
        .m1_b_valid(m_b_valid[1]), .m1_b_resp(m_b_resp[1]), .m1_b_ready(m_b_ready[1]),
        .m1_ar_valid(m_ar_valid[1]), .m1_ar_addr(m_ar_addr[1]), .m1_ar_ready(m_ar_ready[1]),
        .m1_r_valid(m_r_valid[1]), .m1_r_data(m_r_data[1]), .m1_r_resp(m_r_resp[1]), .m1_r_ready(m_r_ready[1]),
        .ram_aw_valid(ram_aw_valid), .ram_aw_addr(ram_aw_addr), .ram_aw_ready(ram_aw_ready),
        .ram_w_valid(ram_w_valid), .ram_w_data(ram_w_data), .ram_w_ready(ram_w_ready),
        .ram_b_valid(ram_b_valid), .ram_b_resp(ram_b_resp), .ram_b_ready(ram_b_ready),
        .ram_ar_valid(ram_ar_valid), .ram_ar_addr(ram_ar_addr), .ram_ar_ready(ram_ar_ready),
        .ram_r_valid(ram_r_valid), .ram_r_data(ram_r_data), .ram_r_resp(ram_r_resp), .ram_r_ready(ram_r_ready),
        .grant(grant), .busy(busy)
    );

    // RAM slave: accepts aw, then w one cycle later, then answers b; reads answer one cycle after ar.
    logic [DW-1:0] mem [0:1023];
    logic          aw_got, w_got;
    logic [AW-1:0] aw_addr_l;
    logic [DW-1:0] w_data_l;
    assign ram_aw_ready = !aw_got && !ram_b_valid;
    assign ram_w_ready  = aw_got && !w_got;
    assign ram_ar_ready = !ram_r_valid;
    assign ram_b_resp   = 2'b00;
    assign ram_r_resp   = 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; ram_b_valid <= 1'b0; ram_r_valid <= 1'b0;
            ram_r_data <= '0; aw_addr_l <= '0; w_data_l <= '0;
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | i;
        end else begin
            if (ram_aw_valid && ram_aw_ready) begin aw_got <= 1'b1; aw_addr_l <= ram_aw_addr; end
            if (ram_w_valid && ram_w_ready) begin w_got <= 1'b1; w_data_l <= ram_w_data; end
            if (aw_got && w_got && !ram_b_valid) begin
                mem[aw_addr_l] <= w_data_l; ram_b_valid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (ram_b_valid && ram_b_ready) ram_b_valid <= 1'b0;
            if (ram_ar_valid && ram_ar_ready) begin ram_r_valid <= 1'b1; ram_r_data <= mem[ram_ar_addr]; end
            if (ram_r_valid && ram_r_ready) ram_r_valid <= 1'b0;
        end
    end

    int checks = 0;
    int failures = 0;
    // Transaction-level model: who owns the bus, for what kind of transfer, who owned it last.
    int own = -1, own_n = -1, last = 1, last_n = 1;
    bit wr = 1'b0, wr_n = 1'b0;
    logic [1:0] glog[$];
    int gaps[$];
    logic [1:0] prev_g = 2'b00;
    int idle_run = 0;
    bit had_grant = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [40:0] m_act(input int k);
        return {m_aw_ready[k], m_w_ready[k], m_b_valid[k], m_b_resp[k],
                m_ar_ready[k], m_r_valid[k], m_r_data[k], m_r_resp[k]};
    endfunction

    function automatic logic [40:0] m_exp(input int k);
        if (own != k) return '0;
        if (wr) return {ram_aw_ready, ram_w_ready, ram_b_valid, ram_b_resp, 1'b0, 1'b0, {DW{1'b0}}, 2'b00};
        return {1'b0, 1'b0, 1'b0, 2'b00, ram_ar_ready, ram_r_valid, ram_r_data, ram_r_resp};
    endfunction

    function automatic logic [56:0] ram_act();
        return {ram_aw_valid, ram_aw_addr, ram_w_valid, ram_w_data, ram_b_ready,
                ram_ar_valid, ram_ar_addr, ram_r_ready};
    endfunction

    function automatic logic [56:0] ram_exp();
        if (own < 0) return '0;
        if (wr) return {m_aw_valid[own], m_aw_addr[own], m_w_valid[own], m_w_data[own], m_b_ready[own],
                        1'b0, {AW{1'b0}}, 1'b0};
        return {1'b0, {AW{1'b0}}, 1'b0, {DW{1'b0}}, 1'b0, m_ar_valid[own], m_ar_addr[own], m_r_ready[own]};
    endfunction

    task automatic do_write(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int bdelay, output int bwait);
        int  cyc;
        bit  aw_h, w_h, b_h, done;
        cyc = 0; done = 1'b0; bwait = 0;
        m_aw_addr[m] = a; m_w_data[m] = d;
        m_aw_valid[m] = 1'b1; m_w_valid[m] = 1'b1; m_b_ready[m] = (bdelay == 0);
        while (!done && cyc < 200) begin
            @(negedge clk);
            aw_h = m_aw_valid[m] && m_aw_ready[m];
            w_h  = m_w_valid[m] && m_w_ready[m];
            b_h  = m_b_valid[m] && m_b_ready[m];
            if (m_b_valid[m] && !m_b_ready[m]) bwait++;
            @(posedge clk); #1;
            if (aw_h) m_aw_valid[m] = 1'b0;
            if (w_h) m_w_valid[m] = 1'b0;
            if (b_h) begin m_b_ready[m] = 1'b0; done = 1'b1; end
            else if (bwait >= bdelay) m_b_ready[m] = 1'b1;
            cyc++;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL write_timeout m%0d addr %h: no b handshake within 200 cycles", m, a);
            m_aw_valid[m] = 1'b0; m_w_valid[m] = 1'b0; m_b_ready[m] = 1'b0;
        end
    endtask

    task automatic do_read(input int m, input logic [AW-1:0] a, output logic [DW-1:0] d);
        int  cyc;
        bit  ar_h, r_h, done;
        cyc = 0; done = 1'b0; d = '0;
        m_ar_addr[m] = a; m_ar_valid[m] = 1'b1; m_r_ready[m] = 1'b1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            ar_h = m_ar_valid[m] && m_ar_ready[m];
            r_h  = m_r_valid[m] && m_r_ready[m];
            if (r_h) d = m_r_data[m];
            @(posedge clk); #1;
            if (ar_h) m_ar_valid[m] = 1'b0;
            if (r_h) begin m_r_ready[m] = 1'b0; done = 1'b1; end
            cyc++;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL read_timeout m%0d addr %h: no r handshake within 200 cycles", m, a);
            m_ar_valid[m] = 1'b0; m_r_ready[m] = 1'b0;
        end
    endtask

    task automatic clear_log();
        glog.delete(); gaps.delete(); had_grant = 1'b0;
    endtask

    logic [DW-1:0] d0, d1;
    int bw, dummy;
    bit r0, r1;
    int p;
    bit wait_ok;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_aw_valid[k] = 1'b0; m_w_valid[k] = 1'b0; m_b_ready[k] = 1'b0;
            m_ar_valid[k] = 1'b0; m_r_ready[k] = 1'b0;
            m_aw_addr[k] = '0; m_ar_addr[k] = '0; m_w_data[k] = '0;
        end
        #1 rst_n = 1'b0;
        fork
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin own = -1; wr = 1'b0; last = 1; end
                else begin own = own_n; wr = wr_n; last = last_n; end
            end
            forever begin
                @(negedge clk);
                chk("grant", {62'd0, grant}, (own < 0) ? 64'd0 : ((own == 0) ? 64'd1 : 64'd2));
                chk("busy", {63'd0, busy}, {63'd0, own >= 0});
                chk("m0_outputs", {23'd0, m_act(0)}, {23'd0, m_exp(0)});
                chk("m1_outputs", {23'd0, m_act(1)}, {23'd0, m_exp(1)});
                chk("ram_outputs", {7'd0, ram_act()}, {7'd0, ram_exp()});
                own_n = own; wr_n = wr; last_n = last;
                if (!rst_n) begin
                    own_n = -1; wr_n = 1'b0; last_n = 1;
                end else if (own < 0) begin
                    r0 = m_aw_valid[0] || m_ar_valid[0];
                    r1 = m_aw_valid[1] || m_ar_valid[1];
                    if (r0 || r1) begin
                        p = (r0 && r1) ? (1 - last) : (r0 ? 0 : 1);
                        own_n = p; wr_n = m_aw_valid[p]; last_n = p;
                    end
                end else if (wr ? (ram_b_valid && m_b_ready[own]) : (ram_r_valid && m_r_ready[own])) begin
                    own_n = -1;
                end
                if (grant != prev_g && grant != 2'b00) begin
                    glog.push_back(grant);
                    if (had_grant) gaps.push_back(idle_run);
                    had_grant = 1'b1;
                end
                idle_run = (grant == 2'b00) ? idle_run + 1 : 0;
                prev_g = grant;
            end
            begin
                repeat (3) @(negedge clk);
                #2 rst_n = 1'b1;
                @(posedge clk); #1;
                chk("reset_grant", {62'd0, grant}, 64'd0);
                chk("reset_busy", {63'd0, busy}, 64'd0);

                // m0 write then read-back while m1 idle
                fork
                    do_write(0, 10'h010, 32'hDEAD_BEEF, 0, dummy);
                    begin
                        @(negedge clk); chk("t1_grant_before", {62'd0, grant}, 64'd0);
                        @(negedge clk); chk("t1_grant_after", {62'd0, grant}, 64'd1);
                    end
                join
                @(negedge clk); chk("t1_grant_released", {62'd0, grant}, 64'd0);
                @(posedge clk); #1;
                do_read(0, 10'h010, d0);
                chk("t1_readback", {32'd0, d0}, 64'hDEAD_BEEF);

                // m1 single write so m1 is the last owner
                do_write(1, 10'h030, 32'h0BAD_F00D, 0, dummy);

                // simultaneous reads
                clear_log();
                fork
                    do_read(0, 10'h004, d0);
                    do_read(1, 10'h008, d1);
                join
                chk("t2_m0_data", {32'd0, d0}, 64'hA000_0004);
                chk("t2_m1_data", {32'd0, d1}, 64'hA000_0008);
                chk("t2_grant0", {62'd0, glog[0]}, 64'd1);
                chk("t2_grant1", {62'd0, glog[1]}, 64'd2);

                // both masters stream writes
                clear_log();
                fork
                    for (int i = 0; i < 3; i++) do_write(0, 10'h100 + 10'(i * 4), 32'h1000 + i, 0, dummy);
                    for (int j = 0; j < 3; j++) do_write(1, 10'h200 + 10'(j * 4), 32'h2000 + j, 0, bw);
                join
                chk("t3_grant_count", 64'(glog.size()), 64'd6);
                for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), {62'd0, glog[i]}, (i % 2) ? 64'd2 : 64'd1);
                for (int i = 0; i < 5; i++) chk($sformatf("t3_gap%0d", i), 64'(gaps[i]), 64'd1);

                // m1 aw and ar together: write first, then the read sees it
                clear_log();
                fork
                    do_write(1, 10'h040, 32'h1234_5678, 0, dummy);
                    do_read(1, 10'h040, d1);
                join
                chk("t4_read_data", {32'd0, d1}, 64'h1234_5678);
                chk("t4_grant0", {62'd0, glog[0]}, 64'd2);
                chk("t4_grant1", {62'd0, glog[1]}, 64'd2);

                // owner stalls b_ready for 5 cycles while m1 waits
                clear_log();
                fork
                    do_write(0, 10'h050, 32'h55AA_55AA, 5, bw);
                    do_write(1, 10'h054, 32'h0000_0066, 0, dummy);
                join
                chk("t5_bwait", 64'(bw), 64'd5);
                chk("t5_grant0", {62'd0, glog[0]}, 64'd1);
                chk("t5_grant1", {62'd0, glog[1]}, 64'd2);

                // reset between aw acceptance and w
                m_aw_addr[0] = 10'h060; m_w_data[0] = 32'hCAFE_0001;
                m_aw_valid[0] = 1'b1; m_w_valid[0] = 1'b1; m_b_ready[0] = 1'b1;
                wait_ok = 1'b0;
                for (int c = 0; c < 20 && !wait_ok; c++) begin
                    @(negedge clk);
                    wait_ok = m_aw_ready[0];
                end
                chk("t6_aw_ready_seen", {63'd0, wait_ok}, 64'd1);
                @(posedge clk); #1;
                m_aw_valid[0] = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                chk("t6_async_grant", {62'd0, grant}, 64'd0);
                chk("t6_async_busy", {63'd0, busy}, 64'd0);
                chk("t6_async_m0", {23'd0, m_act(0)}, 64'd0);
                chk("t6_async_ram", {7'd0, ram_act()}, 64'd0);
                m_w_valid[0] = 1'b0; m_b_ready[0] = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
                @(posedge clk); #1;
                clear_log();
                fork
                    do_read(0, 10'h010, d0);
                    do_read(1, 10'h014, d1);
                join
                chk("t6_first_grant", {62'd0, glog[0]}, 64'd1);
                chk("t6_m0_data", {32'd0, d0}, 64'hA000_0010);
                chk("t6_m1_data", {32'd0, d1}, 64'hA000_0014);

                repeat (2) @(negedge clk);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        join
    end
endmodule
`default_nettype wire
